oldprd_queue: RTL

- Circular queue that records the previous physical mapping (old prd) of every renamed destination, in program order.
- Written by rename. At commit it releases those old prds, in order, toward the freelist commit-write port (commit_prd plus per-slot enables).
- During a misprediction walk it discards the youngest entries so they are never released.
- Sits between the rename table and the freelist, one instance per register file (int/fp).

---
 rtl/oldprd_queue_pkg.sv | 37 +++
 rtl/oldprd_rel_stage.sv | 30 +++
 rtl/oldprd_queue.sv | 114 +++++++++++
 3 files changed

// File: rtl/oldprd_queue_pkg.sv
// Shared widths, prd/pointer types and the popcount / compaction-offset helpers
// used by the old-prd queue.
package oldprd_queue_pkg;

  localparam int FETCH_WIDTH  = 4;
  localparam int COMMIT_WIDTH = 4;
  localparam int PREG_WIDTH   = 7;
  localparam int DEPTH        = 128;
  localparam int PTR_W        = $clog2(DEPTH);
  localparam int CNT_W        = PTR_W + 1;
  localparam int FW_NUM_W     = $clog2(FETCH_WIDTH) + 1;
  localparam int CW_NUM_W     = $clog2(COMMIT_WIDTH) + 1;

  typedef logic [PREG_WIDTH-1:0] prd_t;
  typedef logic [FW_NUM_W-1:0]   fw_num_t;

  // The wrap bit lets tail - head distinguish a full queue from an empty one.
  typedef struct packed {
    logic             wrap;
    logic [PTR_W-1:0] idx;
  } ptr_t;

  function automatic fw_num_t parallel_adder(input logic [FETCH_WIDTH-1:0] v);
    fw_num_t s;
    s = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) s = s + fw_num_t'(v[i]);
    return s;
  endfunction

  function automatic fw_num_t cal_valid_num(input logic [FETCH_WIDTH-1:0] v, input int slot);
    fw_num_t s;
    s = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) if (i < slot) s = s + fw_num_t'(v[i]);
    return s;
  endfunction

endpackage

// File: rtl/oldprd_rel_stage.sv
// Registered release stage: holds rel_en/rel_prd for exactly one cycle after
// the commit that read them; cleared asynchronously by reset.
module oldprd_rel_stage
  import oldprd_queue_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic [COMMIT_WIDTH-1:0]            i_rel_en,
  input  logic [COMMIT_WIDTH*PREG_WIDTH-1:0] i_rel_prd,
  output logic [COMMIT_WIDTH-1:0]            o_rel_en,
  output logic [COMMIT_WIDTH*PREG_WIDTH-1:0] o_rel_prd
);

  logic [COMMIT_WIDTH-1:0]            r_rel_en;
  logic [COMMIT_WIDTH*PREG_WIDTH-1:0] r_rel_prd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rel_en  <= '0;
      r_rel_prd <= '0;
    end else begin
      r_rel_en  <= i_rel_en;
      r_rel_prd <= i_rel_prd;
    end
  end

  assign o_rel_en  = r_rel_en;
  assign o_rel_prd = r_rel_prd;

endmodule

// File: rtl/oldprd_queue.sv
// In-order queue of old prds: rename writes at tail, commit releases from head
// one cycle later, a walk rewinds tail. OLDPRD_QUEUE_CHECK_EN adds sticky err and clamping.
module oldprd_queue
  import oldprd_queue_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic [FETCH_WIDTH-1:0]             ren_en,
  input  logic [FETCH_WIDTH*PREG_WIDTH-1:0]  ren_old_prd,
  input  logic                               ren_stall,
  output logic                               full,
  input  logic [CW_NUM_W-1:0]                commit_num,
  input  logic                               walk,
  input  logic [CW_NUM_W-1:0]                walk_num,
  output logic [COMMIT_WIDTH-1:0]            rel_en,
  output logic [COMMIT_WIDTH*PREG_WIDTH-1:0] rel_prd,
`ifdef OLDPRD_QUEUE_CHECK_EN
  output logic                               err,
`endif
  output logic [CNT_W-1:0]                   count
);

  ptr_t r_head, r_tail;
  logic r_full;
  prd_t r_mem [DEPTH];

  logic [FETCH_WIDTH-1:0]             w_wr_en;
  fw_num_t                            w_wr_num;
  logic [CW_NUM_W-1:0]                w_k, w_walk;
  logic [CNT_W-1:0]                   w_count, w_count_nxt;
  ptr_t                               w_head_nxt, w_tail_nxt;
  logic [PTR_W-1:0]                   w_wr_addr [FETCH_WIDTH];
  logic [PTR_W-1:0]                   w_rd_addr [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0]            w_rd_en;
  logic [COMMIT_WIDTH*PREG_WIDTH-1:0] w_rd_prd;

  assign w_count  = {r_tail} - {r_head};
  assign w_wr_en  = (~ren_stall & ~walk & ~r_full) ? ren_en : '0;
  assign w_wr_num = parallel_adder(w_wr_en);

`ifdef OLDPRD_QUEUE_CHECK_EN
  logic [CNT_W-1:0] w_avail;
  logic             w_err_set;
  logic             r_err;

  // Clamp commit first, then the walk against whatever commit leaves behind.
  assign w_k     = (CNT_W'(commit_num) > w_count) ? CW_NUM_W'(w_count) : commit_num;
  assign w_avail = w_count - CNT_W'(w_k);
  assign w_walk  = !walk ? '0 :
                   (CNT_W'(walk_num) > w_avail) ? CW_NUM_W'(w_avail) : walk_num;
  assign w_err_set = ((|ren_en) & ~ren_stall & ~walk & r_full)
                   | (CNT_W'(commit_num) > w_count)
                   | (walk & (CNT_W'(walk_num) > w_avail))
                   | (walk & (|ren_en));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign w_k    = commit_num;
  assign w_walk = walk ? walk_num : '0;
`endif

  assign w_head_nxt  = ptr_t'({r_head} + CNT_W'(w_k));
  assign w_tail_nxt  = ptr_t'({r_tail} + CNT_W'(w_wr_num) - CNT_W'(w_walk));
  assign w_count_nxt = {w_tail_nxt} - {w_head_nxt};

  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++)
      w_wr_addr[i] = r_tail.idx + PTR_W'(cal_valid_num(w_wr_en, i));
  end

  always_comb begin
    w_rd_prd = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      w_rd_addr[i] = r_head.idx + PTR_W'(i);
      w_rd_en[i]   = CW_NUM_W'(i) < w_k;
      if (w_rd_en[i]) w_rd_prd[i*PREG_WIDTH +: PREG_WIDTH] = r_mem[w_rd_addr[i]];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++)
      if (w_wr_en[i]) r_mem[w_wr_addr[i]] <= ren_old_prd[i*PREG_WIDTH +: PREG_WIDTH];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_full <= 1'b0;
    end else begin
      r_head <= w_head_nxt;
      r_tail <= w_tail_nxt;
      r_full <= (CNT_W'(DEPTH) - w_count_nxt) < CNT_W'(FETCH_WIDTH);
    end
  end

  oldprd_rel_stage u_rel_stage (
    .clk       (clk),
    .rst       (rst),
    .i_rel_en  (w_rd_en),
    .i_rel_prd (w_rd_prd),
    .o_rel_en  (rel_en),
    .o_rel_prd (rel_prd)
  );

  assign full  = r_full;
  assign count = w_count;

endmodule
